data_buffer_engine: RTL and testbench

DATA_BUFFER_ENGINE -- requirements
Module: data_buffer_engine

---
 rtl/data_buffer_pkg.sv | 21 ++
 rtl/buffer_fifo.sv | 64 ++++++
 rtl/data_buffer_engine.sv | 106 ++++++++++
 tb/tb_data_buffer_engine.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_buffer_pkg.sv
`default_nettype none
// ============================================================================
// data_buffer_pkg : shared state encoding and write-transform mode constants
// Revision: 1.0
// ============================================================================
package data_buffer_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam logic [1:0] c_MODE_PASS = 2'd0;
   localparam logic [1:0] c_MODE_INV  = 2'd1;
   localparam logic [1:0] c_MODE_AND  = 2'd2;
   localparam logic [1:0] c_MODE_REV  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/buffer_fifo.sv
`default_nettype none
// ============================================================================
// buffer_fifo : circular word storage with wrap-around pointers and occupancy
// Revision: 1.0
// ============================================================================
module buffer_fifo
   import data_buffer_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [WIDTH-1:0]      wdata_i,
   output logic [WIDTH-1:0]      rdata_o,
   output logic [ADDR_WIDTH:0]   count_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam logic [ADDR_WIDTH:0] c_FULL = (ADDR_WIDTH+1)'(DEPTH);

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q;
   logic [ADDR_WIDTH-1:0] rd_ptr_q;
   logic [ADDR_WIDTH:0]   count_q;
   logic                  do_push;
   logic                  do_pop;

   assign full_o  = (count_q == c_FULL);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // DEPTH is a power of two, so plain pointer overflow is the modulo wrap
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (ADDR_WIDTH+1)'(1);
            2'b01:   count_q <= count_q - (ADDR_WIDTH+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/data_buffer_engine.sv
`default_nettype none
// ============================================================================
// data_buffer_engine : run/drain controlled buffer with write-time transforms
// Revision: 1.0
// ============================================================================
module data_buffer_engine
   import data_buffer_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic [1:0]            mode,
   input  logic [WIDTH-1:0]      mask,
   input  logic [WIDTH-1:0]      data_in,
   input  logic                  data_valid,
   output logic                  data_ready,
   output logic [WIDTH-1:0]      data_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   input  logic [ADDR_WIDTH:0]   threshold,
   output logic [ADDR_WIDTH:0]   count,
   output logic [3:0]            status,
   output logic                  interrupt,
   output logic                  error_flag,
   input  logic                  clear_err,
   output logic                  task_done
);

   state_e           state_q;
   logic             err_q;
   logic             done_q;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             drop;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] rdata;

   assign data_ready = (state_q == S_RUN) && !full;
   assign out_valid  = !empty && ((state_q == S_RUN) || (state_q == S_DRAIN));
   assign push       = data_valid && data_ready;
   assign pop        = out_valid && out_ready;
   assign drop       = data_valid && (state_q != S_RUN);
   assign data_out   = out_valid ? rdata : '0;
   assign interrupt  = (threshold != '0) && (count >= threshold);
   assign status     = {full, empty, state_q};
   assign error_flag = err_q;
   assign task_done  = done_q;

   always_comb begin
      wdata = data_in;
      case (mode)
         c_MODE_INV: wdata = ~data_in;
         c_MODE_AND: wdata = data_in & mask;
         c_MODE_REV: for (int i = 0; i < WIDTH; i++) wdata[i] = data_in[WIDTH-1-i];
         default:    wdata = data_in;
      endcase
   end

   buffer_fifo #(
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wdata),
      .rdata_o (rdata),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );

   // A drop in the same cycle as clear_err keeps the flag set
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE:  if (start) state_q <= S_RUN;
            S_RUN:   if (stop)  state_q <= S_DRAIN;
            S_DRAIN: if (empty) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                     end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
         if (drop)           err_q <= 1'b1;
         else if (clear_err) err_q <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_buffer_engine.sv
`default_nettype none
// ============================================================================
// tb_data_buffer_engine : scenario tasks checked against a queue-based model
// Revision: 1.0
// ============================================================================
module tb_data_buffer_engine;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0, stop = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [7:0] mask = 8'h00, data_in = 8'h00;
   logic       data_valid = 1'b0, out_ready = 1'b0, clear_err = 1'b0;
   logic [4:0] threshold = 5'd0;
   logic       data_ready, out_valid, interrupt, error_flag, task_done;
   logic [7:0] data_out;
   logic [4:0] count;
   logic [3:0] status;

   int errors = 0;
   int checks = 0;

   // Reference model: FIFO contents, phase (0 idle,1 run,2 drain,3 done), sticky error
   logic [7:0] m_q[$];
   int         m_state = 0;
   bit         m_err = 1'b0;

   data_buffer_engine #(.WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode), .mask(mask),
      .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
      .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
      .threshold(threshold), .count(count), .status(status), .interrupt(interrupt),
      .error_flag(error_flag), .clear_err(clear_err), .task_done(task_done)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] xform(input logic [1:0] md, input logic [7:0] d, input logic [7:0] mk);
      logic [7:0] r;
      r = 8'h00;
      case (md)
         2'd0:    r = d;
         2'd1:    r = 8'hFF - d;
         2'd2:    r = d & mk;
         default: for (int i = 0; i < 8; i++) r = {r[6:0], d[i]};
      endcase
      return r;
   endfunction

   // Advance one clock; model follows the rules using inputs present before the edge
   task automatic tick();
      bit         push, pop, was_empty;
      logic [7:0] w;
      was_empty = (m_q.size() == 0);
      push = data_valid && (m_state == 1) && (m_q.size() < 16);
      pop  = out_ready && !was_empty && (m_state == 1 || m_state == 2);
      w    = xform(mode, data_in, mask);
      @(posedge clk);
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(w);
      if (data_valid && m_state != 1) m_err = 1'b1;
      else if (clear_err)             m_err = 1'b0;
      case (m_state)
         0:       if (start) m_state = 1;
         1:       if (stop)  m_state = 2;
         2:       if (was_empty) m_state = 3;
         default: m_state = 0;
      endcase
      #1;
   endtask

   task automatic finish_run();
      stop = 1'b1; tick(); stop = 1'b0;
      data_valid = 1'b0; out_ready = 1'b1;
      for (int g = 0; g < 40 && m_state != 0; g++) tick();
      out_ready = 1'b0;
      checks++;
      if (status[1:0] !== 2'd0 || count !== 5'd0) begin
         errors++; $display("FAIL finish_run: status=%b count=%0d, required idle and empty", status, count);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk); #1;
      checks++;
      if ({count, status, data_ready, out_valid, data_out, interrupt, error_flag, task_done} !== {5'd0, 4'b0100, 1'b0, 1'b0, 8'h00, 3'b000}) begin
         errors++; $display("FAIL reset_initial: count=%0d status=%b dr=%b ov=%b do=%h irq=%b err=%b done=%b",
                             count, status, data_ready, out_valid, data_out, interrupt, error_flag, task_done);
      end
      reset = 1'b1;
      data_valid = 1'b1; data_in = 8'h11; tick(); data_valid = 1'b0;
      checks++;
      if (error_flag !== 1'b1) begin errors++; $display("FAIL idle_write_err: got %b need 1", error_flag); end
      threshold = 5'd2; start = 1'b1; tick(); start = 1'b0;
      data_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin data_in = 8'($urandom); tick(); end
      data_valid = 1'b0;
      checks++;
      if (count !== 5'd5 || interrupt !== 1'b1 || status[1:0] !== 2'd1) begin
         errors++; $display("FAIL pre_reset: count=%0d irq=%b st=%0d need 5/1/1", count, interrupt, status[1:0]);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      m_q.delete(); m_state = 0; m_err = 1'b0;
      checks++;
      if ({count, status, data_ready, out_valid, data_out, interrupt, error_flag, task_done} !== {5'd0, 4'b0100, 1'b0, 1'b0, 8'h00, 3'b000}) begin
         errors++; $display("FAIL reset_midrun: count=%0d status=%b dr=%b ov=%b do=%h irq=%b err=%b done=%b",
                             count, status, data_ready, out_valid, data_out, interrupt, error_flag, task_done);
      end
      reset = 1'b1;
      repeat (3) tick();
      checks++;
      if (status !== 4'b0100 || data_ready !== 1'b0) begin
         errors++; $display("FAIL post_reset_wait: status=%b dr=%b need 0100/0", status, data_ready);
      end
      threshold = 5'd0;
   endtask

   task automatic test_transform();
      logic [7:0] expv [4];
      expv = '{8'hA5, 8'h5A, 8'h05, 8'hA5};
      start = 1'b1; tick(); start = 1'b0;
      out_ready = 1'b0; mask = 8'h0F; data_in = 8'hA5; data_valid = 1'b1;
      for (int m = 0; m < 4; m++) begin
         mode = 2'(m); tick();
         if (m == 0) begin
            checks++;
            if (out_valid !== 1'b1 || data_out !== 8'hA5) begin
               errors++; $display("FAIL latency: ov=%b do=%h need 1/a5", out_valid, data_out);
            end
         end
      end
      data_valid = 1'b0; mode = 2'd0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_valid !== 1'b1 || data_out !== expv[i]) begin
            errors++; $display("FAIL transform[%0d]: ov=%b got %h need %h", i, out_valid, data_out, expv[i]);
         end
         tick();
      end
      out_ready = 1'b0;
      finish_run();
   endtask

   task automatic test_full();
      start = 1'b1; tick(); start = 1'b0;
      out_ready = 1'b0; data_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         data_in = 8'($urandom); mode = 2'($urandom); mask = 8'($urandom); tick();
      end
      checks++;
      if (count !== 5'd16 || status[3] !== 1'b1 || data_ready !== 1'b0) begin
         errors++; $display("FAIL full: count=%0d full=%b dr=%b need 16/1/0", count, status[3], data_ready);
      end
      data_in = 8'h3C; mode = 2'd0;
      repeat (3) tick();
      checks++;
      if (count !== 5'd16 || error_flag !== 1'b0) begin
         errors++; $display("FAIL full_hold: count=%0d err=%b need 16/0", count, error_flag);
      end
      out_ready = 1'b1;
      checks++;
      if (data_ready !== 1'b0 || data_out !== m_q[0]) begin
         errors++; $display("FAIL full_pop: dr=%b do=%h need 0/%h", data_ready, data_out, m_q[0]);
      end
      tick();
      checks++;
      if (data_ready !== 1'b1 || count !== 5'd15) begin
         errors++; $display("FAIL after_pop: dr=%b count=%0d need 1/15", data_ready, count);
      end
      tick(); data_valid = 1'b0;
      checks++;
      if (count !== 5'd15) begin errors++; $display("FAIL push_pop_15: count=%0d need 15", count); end
      for (int g = 0; g < 20 && m_q.size() > 0; g++) begin
         checks++;
         if (data_out !== m_q[0] || (m_q.size() == 1 && data_out !== 8'h3C)) begin
            errors++; $display("FAIL full_drain: got %h need %h", data_out, m_q[0]);
         end
         tick();
      end
      out_ready = 1'b0;
      finish_run();
   endtask

   task automatic test_interrupt();
      threshold = 5'd4;
      start = 1'b1; tick(); start = 1'b0;
      out_ready = 1'b0; data_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         data_in = 8'($urandom); tick();
         checks++;
         if (interrupt !== (i == 3)) begin
            errors++; $display("FAIL irq_rise[%0d]: got %b need %b", i, interrupt, (i == 3));
         end
      end
      data_valid = 1'b0; out_ready = 1'b1; tick(); out_ready = 1'b0;
      checks++;
      if (interrupt !== 1'b0 || count !== 5'd3) begin
         errors++; $display("FAIL irq_fall: irq=%b count=%0d need 0/3", interrupt, count);
      end
      threshold = 5'd3; #1;
      checks++;
      if (interrupt !== 1'b1) begin errors++; $display("FAIL irq_equal: got %b need 1", interrupt); end
      threshold = 5'd0; #1;
      checks++;
      if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_disabled: got %b need 0", interrupt); end
      finish_run();
   endtask

   task automatic test_drain();
      stop = 1'b1; tick(); stop = 1'b0;
      checks++;
      if (status[1:0] !== 2'd0) begin errors++; $display("FAIL stop_in_idle: state=%0d need 0", status[1:0]); end
      start = 1'b1; tick(); start = 1'b0;
      out_ready = 1'b0; mode = 2'd0; data_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin data_in = 8'h10 + 8'(i); tick(); end
      data_valid = 1'b0;
      stop = 1'b1; tick(); stop = 1'b0;
      data_valid = 1'b1; data_in = 8'hEE; tick(); data_valid = 1'b0;
      checks++;
      if (error_flag !== 1'b1 || count !== 5'd3 || status[1:0] !== 2'd2) begin
         errors++; $display("FAIL drain_drop: err=%b count=%0d st=%0d need 1/3/2", error_flag, count, status[1:0]);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid !== 1'b1 || data_out !== 8'h10 + 8'(i)) begin
            errors++; $display("FAIL drain_read[%0d]: ov=%b got %h need %h", i, out_valid, data_out, 8'h10 + 8'(i));
         end
         tick();
      end
      out_ready = 1'b0;
      checks++;
      if (status !== 4'b0110 || task_done !== 1'b0) begin
         errors++; $display("FAIL drain_empty: status=%b done=%b need 0110/0", status, task_done);
      end
      tick();
      checks++;
      if (status[1:0] !== 2'd3 || task_done !== 1'b1) begin
         errors++; $display("FAIL done_state: st=%0d done=%b need 3/1", status[1:0], task_done);
      end
      tick();
      checks++;
      if (status[1:0] !== 2'd0 || task_done !== 1'b0) begin
         errors++; $display("FAIL back_idle: st=%0d done=%b need 0/0", status[1:0], task_done);
      end
      data_valid = 1'b1; clear_err = 1'b1; tick(); data_valid = 1'b0;
      checks++;
      if (error_flag !== 1'b1) begin errors++; $display("FAIL set_wins: got %b need 1", error_flag); end
      tick(); clear_err = 1'b0;
      checks++;
      if (error_flag !== m_err || error_flag !== 1'b0) begin errors++; $display("FAIL clear_err: got %b need 0", error_flag); end
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0;
      checks++;
      if (status[1:0] !== 2'd1) begin errors++; $display("FAIL start_wins: st=%0d need 1", status[1:0]); end
      tick(); stop = 1'b0;
      tick();
      checks++;
      if (status[1:0] !== 2'd3 || task_done !== 1'b1) begin
         errors++; $display("FAIL empty_stop: st=%0d done=%b need 3/1", status[1:0], task_done);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      start = 1'b1; tick(); start = 1'b0;
      out_ready = 1'b0; data_valid = 1'b1; data_in = 8'($urandom); tick();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         data_in = 8'($urandom); mode = 2'($urandom); mask = 8'($urandom);
         checks++;
         if (count !== 5'd1 || out_valid !== 1'b1 || data_out !== m_q[0]) begin
            errors++; $display("FAIL b2b[%0d]: count=%0d ov=%b got %h need 1/1/%h", i, count, out_valid, data_out, m_q[0]);
         end
         tick();
      end
      data_valid = 1'b0; tick(); out_ready = 1'b0;
      checks++;
      if (count !== 5'd0) begin errors++; $display("FAIL b2b_empty: count=%0d need 0", count); end
      finish_run();
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      threshold = 5'($urandom_range(0, 16));
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 0; c < 400; c++) begin
         data_valid = ($urandom % 4) != 0;
         out_ready  = (c < 200) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
         data_in = 8'($urandom); mode = 2'($urandom); mask = 8'($urandom);
         tick();
         checks++;
         if (count !== 5'(m_q.size()) || out_valid !== (m_q.size() > 0) || data_ready !== (m_q.size() < 16) ||
             (m_q.size() > 0 && data_out !== m_q[0]) ||
             interrupt !== (threshold != 0 && m_q.size() >= int'(threshold)) || error_flag !== 1'b0) begin
            errors++;
            if (bad++ < 5) $display("FAIL random[%0d]: count=%0d ov=%b dr=%b do=%h irq=%b need count=%0d head=%h",
                                     c, count, out_valid, data_ready, data_out, interrupt, m_q.size(),
                                     (m_q.size() > 0) ? m_q[0] : 8'h00);
         end
      end
      data_valid = 1'b0; out_ready = 1'b0;
      finish_run();
      threshold = 5'd0;
   endtask

   initial begin
      test_reset();
      test_transform();
      test_full();
      test_interrupt();
      test_drain();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
